// File: rtl/addsub_pipe_pkg.sv
// Package for addsub_pipe: op-code constants, flag-bus indices and the flag struct.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`include "addsub_defs.vh"

package addsub_pipe_pkg;

    localparam logic OP_ADD = `ADDSUB_OP_ADD;
    localparam logic OP_SUB = `ADDSUB_OP_SUB;

    localparam int FLAG_CF   = `ADDSUB_FLAG_CF;
    localparam int FLAG_OF   = `ADDSUB_FLAG_OF;
    localparam int FLAG_ZF   = `ADDSUB_FLAG_ZF;
    localparam int FLAG_SF   = `ADDSUB_FLAG_SF;
    localparam int FLAG_PF   = `ADDSUB_FLAG_PF;
    localparam int FLAG_SLTU = `ADDSUB_FLAG_SLTU;
    localparam int FLAG_SLT  = `ADDSUB_FLAG_SLT;
    localparam int FLAG_W    = `ADDSUB_FLAG_W;

    // Field order matches the flag-bus indices above (slt is the MSB, cf the LSB).
    typedef struct packed {
        logic slt;
        logic sltu;
        logic pf;
        logic sf;
        logic zf;
        logic of;
        logic cf;
    } flags_t;

endpackage

// File: rtl/addsub_defs.vh
// Shared constants for the add/subtract pipeline: op-codes and flag-bus bit positions.
// The flag bus packs {SLT,SLTu,PF,SF,ZF,OF,CF} from MSB to LSB (7 bits).
// Include-guarded so the package and any other user can pull it in safely.
`ifndef ADDSUB_DEFS_VH
`define ADDSUB_DEFS_VH

`define ADDSUB_OP_ADD 1'b0
`define ADDSUB_OP_SUB 1'b1

`define ADDSUB_FLAG_CF   0
`define ADDSUB_FLAG_OF   1
`define ADDSUB_FLAG_ZF   2
`define ADDSUB_FLAG_SF   3
`define ADDSUB_FLAG_PF   4
`define ADDSUB_FLAG_SLTU 5
`define ADDSUB_FLAG_SLT  6
`define ADDSUB_FLAG_W    7

`endif

// File: rtl/addsub_stage.sv
// One CHUNK-bit slice of the pipelined adder: adds slice IDX using the carry from the previous slice.
// Latency: 1 cycle (registered slice result, carry, zero and parity accumulators).
// Backpressure: loads only when adv_i is high; otherwise every register holds its value.
//
// Ports: clk/rst, adv_i (this stage may load), vld_i/vld_o stage valid, a/b raw operands riding
// along, s partial result (lower slices filled), cy carry into the next slice, z/p running
// slice-zero AND and slice-parity XOR, ctrl op-code, sat saturation request.
module addsub_stage
    import addsub_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic             cy_i,
    input  logic             z_i,
    input  logic             p_i,
    input  logic             ctrl_i,
    input  logic             sat_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] s_o,
    output logic             cy_o,
    output logic             z_o,
    output logic             p_o,
    output logic             ctrl_o,
    output logic             sat_o
);

    logic             vld_q;
    logic [WIDTH-1:0] a_q, b_q, s_q, s_d;
    logic             cy_q, cy_d, z_q, z_d, p_q, p_d, ctrl_q, sat_q;

    logic [CHUNK-1:0] a_sl, b_sl;
    logic [CHUNK:0]   sum;

    always_comb begin
        a_sl = a_i[IDX*CHUNK +: CHUNK];
        // Subtraction is A + ~B + ~Ci; the inverted carry-in is applied once, at slice 0, by the top.
        b_sl = b_i[IDX*CHUNK +: CHUNK] ^ {CHUNK{ctrl_i == OP_SUB}};
        sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, cy_i};
        s_d  = s_i;
        s_d[IDX*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        cy_d = sum[CHUNK];
        z_d  = z_i & (sum[CHUNK-1:0] == '0);
        p_d  = p_i ^ (^sum[CHUNK-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            cy_q   <= 1'b0;
            z_q    <= 1'b0;
            p_q    <= 1'b0;
            ctrl_q <= 1'b0;
            sat_q  <= 1'b0;
        end else if (adv_i) begin
            vld_q <= vld_i;
            if (vld_i) begin
                a_q    <= a_i;
                b_q    <= b_i;
                s_q    <= s_d;
                cy_q   <= cy_d;
                z_q    <= z_d;
                p_q    <= p_d;
                ctrl_q <= ctrl_i;
                sat_q  <= sat_i;
            end
        end
    end

    assign vld_o  = vld_q;
    assign a_o    = a_q;
    assign b_o    = b_q;
    assign s_o    = s_q;
    assign cy_o   = cy_q;
    assign z_o    = z_q;
    assign p_o    = p_q;
    assign ctrl_o = ctrl_q;
    assign sat_o  = sat_q;

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit add/subtract with CF/OF/ZF/SF/PF and signed/unsigned less-than flags.
// Latency: WIDTH/CHUNK cycles from accept to out_valid (slice stages plus the flag/output register).
// Backpressure: valid/ready; each stage loads when empty or when downstream loads; output holds while stalled.
//
// Ports: clk, rst (sync, active-high), in_valid/in_ready, A, B, Ci, Ctrl (0 add, 1 sub),
// out_valid/out_ready, S and flags CF, OF, ZF, SF, PF, SLTu, SLT.
// Optional macro ADDSUB_PIPE_SAT_EN adds input 'sat': on signed overflow S clamps to the signed
// max/min; without it the port is absent and S always wraps.
module addsub_pipe
    import addsub_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic             Ctrl,
`ifdef ADDSUB_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             CF,
    output logic             OF,
    output logic             ZF,
    output logic             SF,
    output logic             PF,
    output logic             SLTu,
    output logic             SLT
);

    localparam int STAGES = WIDTH / CHUNK;

    // The slice stages plus the output register must add up to STAGES cycles, so slice 0 is
    // computed straight off the operand inputs and the flag logic sits in front of the output register.
    // The output register therefore replaces the last slice stage; the final slice is added in the
    // last instance and the flag logic uses its registered result.
    if ((WIDTH % CHUNK) != 0 || WIDTH < 2) begin : g_bad_cfg
        $error("addsub_pipe: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    // Link k feeds slice stage k; link STAGES is the last slice stage's register.
    logic [STAGES:0]  l_vld, l_cy, l_z, l_p, l_ctrl, l_sat;
    logic [WIDTH-1:0] l_a [STAGES+1];
    logic [WIDTH-1:0] l_b [STAGES+1];
    logic [WIDTH-1:0] l_s [STAGES+1];

    logic                 out_vld_q;
    logic [WIDTH-1:0]     s_q, s_d;
    logic [FLAG_W-1:0]    flags_q;
    flags_t               flags_d;
    logic                 out_adv;
    logic [STAGES-1:0]    empty;
    logic [STAGES-1:0]    adv;

    assign l_vld[0]  = in_valid;
    assign l_a[0]    = A;
    assign l_b[0]    = B;
    assign l_s[0]    = '0;
    assign l_cy[0]   = (Ctrl == OP_ADD) ? Ci : ~Ci;
    assign l_z[0]    = 1'b1;
    assign l_p[0]    = 1'b0;
    assign l_ctrl[0] = Ctrl;
`ifdef ADDSUB_PIPE_SAT_EN
    assign l_sat[0]  = sat;
`else
    assign l_sat[0]  = 1'b0;
`endif

    // Stage k may load if the output register frees up or any stage at or beyond k is empty;
    // written in closed form so the ready chain is not a self-referencing vector.
    assign out_adv = !out_vld_q || out_ready;
    assign empty   = ~l_vld[STAGES:1];

    always_comb begin
        adv = '0;
        for (int k = 0; k < STAGES; k++) begin
            adv[k] = out_adv || (|(empty >> k));
        end
    end

    assign in_ready = adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .adv_i  (adv[k]),
            .vld_i  (l_vld[k]),
            .a_i    (l_a[k]),
            .b_i    (l_b[k]),
            .s_i    (l_s[k]),
            .cy_i   (l_cy[k]),
            .z_i    (l_z[k]),
            .p_i    (l_p[k]),
            .ctrl_i (l_ctrl[k]),
            .sat_i  (l_sat[k]),
            .vld_o  (l_vld[k+1]),
            .a_o    (l_a[k+1]),
            .b_o    (l_b[k+1]),
            .s_o    (l_s[k+1]),
            .cy_o   (l_cy[k+1]),
            .z_o    (l_z[k+1]),
            .p_o    (l_p[k+1]),
            .ctrl_o (l_ctrl[k+1]),
            .sat_o  (l_sat[k+1])
        );
    end

    // Final-stage flag and magnitude logic.
    logic             a_msb, b_msb, b_eff_msb, is_sub, of_w, clamp;
    logic [WIDTH-1:0] clamp_val;

    always_comb begin
        is_sub    = (l_ctrl[STAGES] == OP_SUB);
        a_msb     = l_a[STAGES][WIDTH-1];
        b_msb     = l_b[STAGES][WIDTH-1];
        b_eff_msb = b_msb ^ is_sub;
        of_w      = (a_msb == b_eff_msb) && (l_s[STAGES][WIDTH-1] != a_msb);
        clamp     = l_sat[STAGES] & of_w;
        // A positive -> 0111..1, A negative -> 1000..0.
        clamp_val = {a_msb, {(WIDTH-1){~a_msb}}};
        s_d       = clamp ? clamp_val : l_s[STAGES];

        flags_d      = '0;
        flags_d.cf   = l_cy[STAGES] ^ is_sub;
        flags_d.of   = of_w;
        // Accumulated zero/parity describe the wrapped sum; a clamped value is never zero.
        flags_d.zf   = clamp ? 1'b0 : l_z[STAGES];
        flags_d.pf   = clamp ? ~(^clamp_val) : ~l_p[STAGES];
        flags_d.sf   = s_d[WIDTH-1];
        // Unsigned borrow of A - B with no borrow-in.
        flags_d.sltu = (l_a[STAGES] < l_b[STAGES]);
        flags_d.slt  = flags_d.sltu ^ a_msb ^ b_msb;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            s_q       <= '0;
            flags_q   <= '0;
        end else if (out_adv) begin
            out_vld_q <= l_vld[STAGES];
            if (l_vld[STAGES]) begin
                s_q     <= s_d;
                flags_q <= flags_d;
            end
        end
    end

    assign out_valid = out_vld_q;
    assign S         = s_q;
    assign CF        = flags_q[FLAG_CF];
    assign OF        = flags_q[FLAG_OF];
    assign ZF        = flags_q[FLAG_ZF];
    assign SF        = flags_q[FLAG_SF];
    assign PF        = flags_q[FLAG_PF];
    assign SLTu      = flags_q[FLAG_SLTU];
    assign SLT       = flags_q[FLAG_SLT];

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe (WIDTH=32, CHUNK=8): directed vectors, stall, reset flush.
// Latency: expected 4 cycles accept-to-output when unstalled.
// Backpressure: out_ready is pulled low for 3 cycles mid-stream.
module tb_addsub_pipe;

    localparam int  W      = 32;
    localparam int  STAGES = 4;
    localparam time PER    = 10;

    logic          clk, rst, in_valid, in_ready, Ci, Ctrl, out_valid, out_ready;
    logic [W-1:0]  A, B, S;
    logic          CF, OF, ZF, SF, PF, SLTu, SLT;
`ifdef ADDSUB_PIPE_SAT_EN
    logic          sat;
`endif

    addsub_pipe #(.WIDTH(W), .CHUNK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Ci        (Ci),
        .Ctrl      (Ctrl),
`ifdef ADDSUB_PIPE_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .CF        (CF),
        .OF        (OF),
        .ZF        (ZF),
        .SF        (SF),
        .PF        (PF),
        .SLTu      (SLTu),
        .SLT       (SLT)
    );

    initial clk = 1'b0;
    always #(PER/2) clk = ~clk;

    // Directed vectors; flags are {SLT,SLTu,PF,SF,ZF,OF,CF}, all hand-computed.
    logic [31:0] va [13] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000003, 32'h00000001,
                            32'h0000000F, 32'h7FFFFFFF, 32'h00000005, 32'h00000000,
                            32'h12345678, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                            32'h80000000};
    logic [31:0] vb [13] = '{32'h00000001, 32'h00000001, 32'h00000005, 32'h00000002,
                            32'h00000000, 32'h00000001, 32'h00000005, 32'h00000001,
                            32'h11111111, 32'h7FFFFFFF, 32'h80000000, 32'h00000001,
                            32'hFFFFFFFF};
    logic        vci  [13] = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    logic        vsub [13] = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0};
    logic [31:0] vs [13] = '{32'h00000000, 32'h7FFFFFFF, 32'hFFFFFFFD, 32'h00000003,
                            32'h00000010, 32'h80000000, 32'h00000000, 32'hFFFFFFFF,
                            32'h23456789, 32'h80000000, 32'h00000001, 32'h7FFFFFFF,
                            32'h80000000};
    logic [6:0]  vf [13] = '{7'b1010101, 7'b1000010, 7'b1101001, 7'b1110000,
                            7'b0000000, 7'b0001010, 7'b0010100, 7'b1111001,
                            7'b0010000, 7'b1001000, 7'b0000011, 7'b0000010,
                            7'b1101011};

    typedef struct {
        logic [31:0] s;
        logic [6:0]  f;
        time         acc_t;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;
    bit   saw_stall = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Present vector v (optionally saturating) and wait, bounded, until it is accepted.
    task automatic issue(input int v, input bit chk_lat, input bit sat_v);
        exp_t e;
        int   guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        A    = va[v];
        B    = vb[v];
        Ci   = vci[v];
        Ctrl = vsub[v];
`ifdef ADDSUB_PIPE_SAT_EN
        sat  = sat_v;
`else
        if (sat_v) fail_now("sat_not_built");
`endif
        forever begin
            #2;
            if (in_ready) break;
            saw_stall = 1;
            guard++;
            if (guard > 50) begin
                fail_now("accept_timeout");
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        e.s = vs[v];
        e.f = vf[v];
        e.acc_t = $time;
        e.chk_lat = chk_lat;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) fail_now("drain_timeout");
    endtask

    // Monitor: compares every output handshake against the scoreboard head, checks hold stability.
    logic [31:0] held_s;
    bit          held = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                held = 0;
                continue;
            end
            if (held && out_valid) check("hold_S", S, held_s);
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    fail_now("spurious_output");
                end else begin
                    e = sb.pop_front();
                    check("S", S, e.s);
                    check("flags", {SLT, SLTu, PF, SF, ZF, OF, CF}, e.f);
                    if (e.chk_lat)
                        check("latency", ($time - 8 - e.acc_t) / PER, STAGES);
                end
            end
            held   = out_valid && !out_ready;
            held_s = S;
        end
    end

    initial begin
        #(200000);
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int out_base;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Ci = 1'b0; Ctrl = 1'b0;
`ifdef ADDSUB_PIPE_SAT_EN
        sat = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_S", S, 0);
        check("rst_flags", {SLT, SLTu, PF, SF, ZF, OF, CF}, 0);

        // Isolated ops with latency check.
        for (int v = 0; v < 3; v++) begin
            issue(v, 1'b1, 1'b0);
            idle();
            drain();
        end

        // Back-to-back stream with a 3-cycle output stall once results start appearing.
        saw_stall = 0;
        out_base  = n_out;
        fork
            begin
                for (int v = 3; v < 11; v++) issue(v, 1'b0, 1'b0);
                idle();
            end
            begin
                int g = 0;
                do begin
                    @(negedge clk);
                    #1;
                    g++;
                end while (!out_valid && g < 40);
                if (!out_valid) fail_now("stream_no_output");
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("in_ready_drop", saw_stall, 1);
        check("stream_count", n_out - out_base, 8);

        // Reset with three ops in flight: none may ever emerge.
        issue(3, 1'b0, 1'b0);
        issue(4, 1'b0, 1'b0);
        issue(5, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("flush_out_valid", out_valid, 0);
        repeat (8) @(negedge clk);
        #3;
        check("flush_in_ready", in_ready, 1);
        issue(0, 1'b1, 1'b0);
        idle();
        drain();

`ifdef ADDSUB_PIPE_SAT_EN
        issue(11, 1'b0, 1'b1);
        issue(12, 1'b0, 1'b1);
        issue(5, 1'b0, 1'b0);
        idle();
        drain();
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
Parametrised, pipelined add/subtract unit with full flag set and signed/unsigned less-than outputs. It generalises the 32-bit combinational adder/subtractor to WIDTH bits. The carry chain is split into CHUNK-bit slices, with one register stage per slice. Valid/ready handshakes on both sides let it sit between the operand-fetch and writeback stages of the datapath at one operation per cycle.

Parameters:
WIDTH, 32, operand/result width in bits; must be >= 2.
CHUNK, 8, bits resolved per pipeline stage; WIDTH % CHUNK must be 0, otherwise elaboration fails via a generate-time error.
(derived) STAGES = WIDTH/CHUNK, pipeline depth and latency in cycles.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-high.
in_valid  in  1  operand set presented.
in_ready  out  1  unit can accept this cycle.
A  in  WIDTH  operand A.
B  in  WIDTH  operand B.
Ci  in  1  carry-in (add) / borrow-in (sub).
Ctrl  in  1  0 = add, 1 = subtract.
out_valid  out  1  result and flags valid.
out_ready  in  1  consumer accepts this cycle.
S  out  WIDTH  result.
CF  out  1  carry (add) / borrow (sub).
OF  out  1  signed overflow.
ZF  out  1  S == 0.
SF  out  1  S[WIDTH-1].
PF  out  1  even parity of S: 1 when the count of ones in S is even.
SLTu  out  1  A < B, unsigned; independent of Ctrl/Ci.
SLT  out  1  A < B, signed; independent of Ctrl/Ci.

Behaviour:
- Reset: synchronous, active-high on clk. All stage valid bits clear, out_valid=0. S and all flags reset to 0. in_ready=1 on the first cycle after reset deasserts. In-flight operations are discarded, with no partial output.
- Arithmetic:
  - Add: {CF,S} = A + B + Ci.
  - Sub: S = A - B - Ci (mod 2^WIDTH); CF=1 iff A < B + Ci (unsigned borrow).
  - Internally, sub is A + ~B + ~Ci; CF for sub = ~carry_out.
  - OF=1 iff the operand sign bits (B inverted for sub) match each other and differ from S[WIDTH-1].
- Pipeline:
  - Stage k (0..STAGES-1) computes slice k with the carry registered from stage k-1.
  - Upper operand slices and Ctrl/Ci ride along registered.
  - Lower result slices are carried forward.
  - ZF is accumulated per slice (AND of slice-zero) and PF per slice (XOR) as the data moves.
- SLTu/SLT are computed by the final-stage magnitude logic: SLTu = borrow of A-B with no borrow-in; SLT = SLTu XOR A[MSB] XOR B[MSB].
- Latency: an op accepted on edge N (in_valid & in_ready) presents out_valid=1 after edge N+STAGES, provided no stall occurs.
- Handshake:
  - Each stage advances when it is empty or the stage downstream is advancing.
  - in_ready = stage-0 empty OR stage 0 advancing.
  - Output is held stable while out_valid & !out_ready.
  - Throughput is 1 op/cycle when out_ready=1.
  - Order is preserved; no op is lost or duplicated.
- Simultaneous accept and emit in the same cycle is legal when full.
- Ctrl/Ci/A/B are ignored when in_valid=0.

Optional Feature:
Macro ADDSUB_PIPE_SAT_EN.
- Defined:
  - Adds input port sat (1 bit), captured with the operands.
  - When sat=1 and OF=1, S clamps to the signed max (0111..1) if A[MSB]=0, else the signed min (100..0).
  - OF still reports 1; ZF/SF/PF are computed from the clamped S.
- Undefined: port absent, S always wraps.

Decomposition:
- Shared include addsub_defs.vh holds:
  - op-code constants ADDSUB_OP_ADD=1'b0 and ADDSUB_OP_SUB=1'b1;
  - flag bit indices for packing {SLT,SLTu,PF,SF,ZF,OF,CF} into a 7-bit flag bus.
- One sub-module, addsub_stage: a CHUNK-bit slice adder with registered carry, slice-zero and slice-parity, plus a valid/stall register. addsub_pipe instantiates STAGES copies in a generate loop.

Test Plan:
- WIDTH=32, CHUNK=8, add 0xFFFFFFFF+0x1, Ci=0 -> 4 cycles later S=0, CF=1, ZF=1, OF=0, PF=1, SF=0.
- Sub 0x80000000-0x1, Ci=0 -> S=0x7FFFFFFF, OF=1, CF=0, SF=0, SLT=1, SLTu=0.
- Sub 0x3-0x5, Ci=1 -> S=0xFFFFFFFD, CF=1, SF=1, SLTu=1, SLT=1, ZF=0.
- Stream 8 random ops back-to-back, out_ready low for 3 cycles mid-stream -> in_ready drops once all stages are full, outputs match the reference model in order, none dropped or duplicated, S stable during stall.
- Assert rst with 3 ops in flight -> out_valid=0 on the next cycle, no stale result ever emitted; the first new op appears 4 cycles after acceptance.
- With ADDSUB_PIPE_SAT_EN, sat=1, add 0x7FFFFFFF+0x1 -> S=0x7FFFFFFF, OF=1; sat=0 -> S=0x80000000.
